// File: rtl/lcd_ram_writer.sv
// Shadows CPU nibble writes to E0C6S46 display memory and streams the shadow into the
// video RAM once per vsync. Optional skip-if-unchanged mode: define LCD_RAM_WRITER_DIRTY_EN.
module lcd_ram_writer #(
  parameter logic [11:0] DISPLAY_BASE = 12'hE00,
  parameter logic [7:0]  BANK_SIZE    = 8'h50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] cpu_addr,
  input  logic [3:0]  cpu_data,
  input  logic        cpu_we,
  input  logic        vsync,
  output logic        ram_wr_en,
  output logic [7:0]  ram_wr_addr,
  output logic [3:0]  ram_wr_data,
  output logic        copy_active,
  output logic        frame_done
);

  localparam int          DEPTH     = 2 * int'(BANK_SIZE);
  localparam logic [7:0]  LAST      = 8'(DEPTH - 1);
  localparam logic [11:0] BANK1_OFS = 12'h080;
  localparam logic [11:0] BANK_LEN  = {4'h0, BANK_SIZE};

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_COPY
  } state_t;

  state_t      state, next_state;
  logic [7:0]  cnt, cnt_next;
  logic        wr_en_next, done_next;
  logic [7:0]  wr_addr_next;
  logic [3:0]  wr_data_next;
  logic [3:0]  shadow [DEPTH];

  logic [11:0] off;
  logic        wr_hit;
  logic [7:0]  wr_idx;
  logic        shadow_we;
  logic        start_copy;

  // Bank 0 maps to 0..BANK_SIZE-1, bank 1 (BASE+0x80) follows directly after it.
  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    off    = cpu_addr - DISPLAY_BASE;
    wr_hit = 1'b0;
    wr_idx = '0;
    if (off < BANK_LEN) begin
      wr_hit = 1'b1;
      wr_idx = off[7:0];
    end else if (off >= BANK1_OFS && off < BANK1_OFS + BANK_LEN) begin
      wr_hit = 1'b1;
      wr_idx = 8'(off - BANK1_OFS) + BANK_SIZE;
    end
  end

  assign shadow_we = cpu_we && wr_hit;

  // NOTE: the shadow is a real reset target (a reset must blank the display), so it is
  // built from flops with a reset rather than left to an uninitialised RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) shadow[i] <= '0;
    end else if (shadow_we) begin
      shadow[wr_idx] <= cpu_data;
    end
  end

`ifdef LCD_RAM_WRITER_DIRTY_EN
  logic dirty;

  // A write landing in the same cycle the copy starts wins, so it is copied next frame.
  always_ff @(posedge clk) begin
    if (reset)                               dirty <= 1'b0;
    else if (shadow_we)                      dirty <= 1'b1;
    else if (state == S_IDLE && start_copy)  dirty <= 1'b0;
  end

  assign start_copy = vsync && dirty;
`else
  assign start_copy = vsync;
`endif

  // The first COPY write is launched on the vsync edge itself, so slot k appears in cycle N+1+k.
  always_comb begin
    next_state   = state;
    cnt_next     = cnt;
    wr_en_next   = 1'b0;
    wr_addr_next = ram_wr_addr;
    wr_data_next = ram_wr_data;
    done_next    = 1'b0;
    unique case (state)
      S_CLEAR: begin
        if (ram_wr_en && ram_wr_addr == LAST) begin
          next_state = S_IDLE;
        end else begin
          wr_en_next   = 1'b1;
          wr_addr_next = cnt;
          wr_data_next = '0;
          cnt_next     = (cnt == LAST) ? cnt : cnt + 8'd1;
        end
      end
      S_IDLE: begin
        if (start_copy) begin
          next_state   = S_COPY;
          wr_en_next   = 1'b1;
          wr_addr_next = '0;
          wr_data_next = shadow[0];
          cnt_next     = 8'd1;
        end
      end
      S_COPY: begin
        if (ram_wr_en && ram_wr_addr == LAST) begin
          next_state = S_IDLE;
          done_next  = 1'b1;
        end else begin
          wr_en_next   = 1'b1;
          wr_addr_next = cnt;
          wr_data_next = shadow[cnt];
          cnt_next     = (cnt == LAST) ? cnt : cnt + 8'd1;
        end
      end
      default: next_state = S_CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_CLEAR;
      cnt         <= '0;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      frame_done  <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= cnt_next;
      ram_wr_en   <= wr_en_next;
      ram_wr_addr <= wr_addr_next;
      ram_wr_data <= wr_data_next;
      frame_done  <= done_next;
    end
  end

  assign copy_active = (state != S_IDLE);

endmodule

// File: tb/tb_lcd_ram_writer.sv
// Self-checking bench for lcd_ram_writer: scoreboard of expected video RAM writes plus a
// table of CPU address-decode vectors, each followed by a full frame comparison.
module tb_lcd_ram_writer;

`ifdef LCD_RAM_WRITER_DIRTY_EN
  localparam bit DIRTY_EN = 1'b1;
`else
  localparam bit DIRTY_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] cpu_addr = '0;
  logic [3:0]  cpu_data = '0;
  logic        cpu_we = 1'b0;
  logic        vsync = 1'b0;
  logic        ram_wr_en;
  logic [7:0]  ram_wr_addr;
  logic [3:0]  ram_wr_data;
  logic        copy_active;
  logic        frame_done;

  lcd_ram_writer dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data),
    .cpu_we      (cpu_we),
    .vsync       (vsync),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .copy_active (copy_active),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [3:0] data;
  } wr_t;

  typedef struct {
    logic [11:0] addr;
    logic [3:0]  data;
    int          exp_idx;
  } vec_t;

  wr_t        sbq[$];
  vec_t       vecs[11];
  logic [3:0] model_sh [160];
  bit         model_dirty = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         fd_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int map_idx(input logic [11:0] a);
    if (a >= 12'hE00 && a <= 12'hE4F) return int'(a - 12'hE00);
    if (a >= 12'hE80 && a <= 12'hECF) return int'(a - 12'hE80) + 80;
    return -1;
  endfunction

  // Monitor: every write the DUT emits must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (frame_done === 1'b1) fd_count++;
      if (ram_wr_en !== 1'b0) begin
        if (sbq.size() == 0) begin
          check("unexpected_wr", {24'h0, ram_wr_addr}, 32'hFFFF);
        end else begin
          wr_t e;
          e = sbq.pop_front();
          check("wr_addr", ram_wr_addr, e.addr);
          check("wr_data", ram_wr_data, e.data);
          check("active_during_wr", copy_active, 1);
        end
      end
    end
  end

  task automatic do_reset(input int vs_at);
    int fd_before;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_wr_en", ram_wr_en, 0);
    check("rst_wr_addr", ram_wr_addr, 0);
    check("rst_wr_data", ram_wr_data, 0);
    check("rst_copy_active", copy_active, 1);
    check("rst_frame_done", frame_done, 0);
    sbq.delete();
    for (int k = 0; k < 160; k++) begin
      wr_t e;
      model_sh[k] = '0;
      e.addr = 8'(k);
      e.data = 4'h0;
      sbq.push_back(e);
    end
    model_dirty = 1'b0;
    fd_before = fd_count;
    reset = 1'b0;
    for (int j = 0; j <= 170; j++) begin
      vsync = (j == vs_at);
      @(negedge clk);
      if (j == 0 || j == 160) check("clear_active", copy_active, 1);
      if (j == 161) check("clear_inactive", copy_active, 0);
      @(posedge clk); #1;
    end
    vsync = 1'b0;
    check("clear_all_written", sbq.size(), 0);
    check("clear_no_done", fd_count - fd_before, 0);
  endtask

  task automatic do_write(input logic [11:0] a, input logic [3:0] d, input int idx);
    cpu_addr = a;
    cpu_data = d;
    cpu_we   = 1'b1;
    @(posedge clk); #1;
    cpu_we = 1'b0;
    if (idx >= 0) begin
      model_sh[idx] = d;
      model_dirty   = 1'b1;
    end
  endtask

  // One vsync; optional CPU write in cycle N+hz_cycle and optional extra vsync in N+vs2_cycle.
  task automatic run_frame(input int hz_cycle, input logic [11:0] hz_addr,
                           input logic [3:0] hz_data, input int vs2_cycle);
    int hz_idx;
    bit expect_copy;
    int fd_before;
    int done_cyc;
    hz_idx      = (hz_cycle >= 0) ? map_idx(hz_addr) : -1;
    expect_copy = !DIRTY_EN || model_dirty;
    if (expect_copy) begin
      for (int k = 0; k < 160; k++) begin
        wr_t e;
        e.addr = 8'(k);
        e.data = (hz_idx == k && k > hz_cycle) ? hz_data : model_sh[k];
        sbq.push_back(e);
      end
    end
    fd_before = fd_count;
    done_cyc  = 0;
    cpu_addr  = hz_addr;
    cpu_data  = hz_data;
    cpu_we    = (hz_cycle == 0);
    vsync     = 1'b1;
    @(posedge clk); #1;
    for (int j = 1; j <= 200; j++) begin
      vsync  = (j == vs2_cycle);
      cpu_we = (j == hz_cycle);
      @(negedge clk);
      if (j == 2) check("frame_active", copy_active, expect_copy);
      if (frame_done === 1'b1 && done_cyc == 0) done_cyc = j;
      @(posedge clk); #1;
    end
    vsync  = 1'b0;
    cpu_we = 1'b0;
    check("frame_done_cycle", done_cyc, expect_copy ? 161 : 0);
    check("frame_done_count", fd_count - fd_before, expect_copy ? 1 : 0);
    check("frame_all_written", sbq.size(), 0);
    if (hz_idx >= 0) model_sh[hz_idx] = hz_data;
    model_dirty = (expect_copy ? 1'b0 : model_dirty) | (hz_idx >= 0);
  endtask

  initial begin
    vecs[0]  = '{addr: 12'hE05, data: 4'hA, exp_idx: 5};
    vecs[1]  = '{addr: 12'hE85, data: 4'h3, exp_idx: 8'h55};
    vecs[2]  = '{addr: 12'hECF, data: 4'h7, exp_idx: 8'h9F};
    vecs[3]  = '{addr: 12'hE50, data: 4'h1, exp_idx: -1};
    vecs[4]  = '{addr: 12'hE7F, data: 4'h2, exp_idx: -1};
    vecs[5]  = '{addr: 12'hED0, data: 4'h4, exp_idx: -1};
    vecs[6]  = '{addr: 12'hE00, data: 4'h1, exp_idx: 0};
    vecs[7]  = '{addr: 12'hE4F, data: 4'hC, exp_idx: 8'h4F};
    vecs[8]  = '{addr: 12'hE80, data: 4'h2, exp_idx: 8'h50};
    vecs[9]  = '{addr: 12'hDFF, data: 4'h9, exp_idx: -1};
    vecs[10] = '{addr: 12'hF05, data: 4'h6, exp_idx: -1};

    repeat (2) @(posedge clk);
    #1;

    // Reset and CLEAR sweep, with a vsync during CLEAR that must be dropped.
    do_reset(5);

    // vsync with no writes: skipped when dirty tracking is built in, copied otherwise.
    run_frame(-1, 12'h000, 4'h0, -1);

    // Address decode table: each write followed by a full frame.
    for (int i = 0; i < 11; i++) begin
      do_write(vecs[i].addr, vecs[i].data, vecs[i].exp_idx);
      run_frame(-1, 12'h000, 4'h0, -1);
    end

    // Write to idx 0x0A in the cycle it is emitted, plus a second vsync mid-COPY.
    do_write(12'hE11, 4'h8, 8'h11);
    run_frame(11, 12'hE0A, 4'hF, 50);
    run_frame(-1, 12'h000, 4'h0, -1);
    run_frame(-1, 12'h000, 4'h0, -1);

    // Mapped write in the same cycle COPY starts.
    do_write(12'hE02, 4'h6, 2);
    run_frame(0, 12'hE01, 4'h5, -1);
    run_frame(-1, 12'h000, 4'h0, -1);

    // Reset in the middle of a COPY: sweep aborts, CLEAR restarts, shadow is blanked.
    do_write(12'hE03, 4'h9, 3);
    for (int k = 0; k < 160; k++) begin
      wr_t e;
      e.addr = 8'(k);
      e.data = model_sh[k];
      sbq.push_back(e);
    end
    vsync = 1'b1;
    @(posedge clk); #1;
    vsync = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    do_reset(-1);
    do_write(12'hE20, 4'h1, 8'h20);
    run_frame(-1, 12'h000, 4'h0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
